// File: rtl/ritc_input_channel_aligner.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// ritc_input_channel_aligner - finds the 3-bit sample shift that aligns the
// RITC training word, holds it once locked and counts training errors. Rev 1.0
// ---------------------------------------------------------------------------
module ritc_input_channel_aligner #(
  parameter logic [47:0] TRAIN_PATTERN = 48'h000000000007,
  parameter int unsigned LOCK_COUNT    = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [47:0] in_i,
  input  logic        train_i,
  input  logic        restart_i,
  output logic [47:0] out_o,
  output logic        valid_o,
  output logic        locked_o,
  output logic [3:0]  shift_o,
  output logic [7:0]  err_cnt_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    VERIFY = 2'd2,
    LOCKED = 2'd3
  } state_t;

  localparam logic [7:0] LOCK_CNT_C = 8'(LOCK_COUNT);

  state_t      state_q, state_d;
  logic [47:0] prev_q;
  logic [47:0] out_q, out_d;
  logic [3:0]  shift_q, shift_d;
  logic [7:0]  match_q, match_d;
  logic [7:0]  err_q, err_d;
  logic        locked_q, locked_d;

  // Previous word in the low half, so sample j of the window sits at bits [3j+2:3j].
  logic [95:0] window;
  logic [47:0] cand [16];
  logic [15:0] hit;
  logic [3:0]  first_hit;
  logic        any_hit;
  logic        cur_ok;

  assign window = {in_i, prev_q};

  for (genvar s = 0; s < 16; s++) begin : g_cand
    assign cand[s] = window[3*s +: 48];
    assign hit[s]  = (cand[s] == TRAIN_PATTERN);
  end

  always_comb begin
    first_hit = 4'd0;
    for (int s = 15; s >= 0; s--) begin
      if (hit[s]) first_hit = 4'(s);
    end
  end

  assign any_hit = |hit;
  assign cur_ok  = hit[shift_q];
  assign out_d   = cand[shift_q];

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    match_d = match_q;
    err_d   = err_q;
    if (restart_i) begin
      state_d = SEARCH;
      match_d = 8'd0;
      err_d   = 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (train_i) begin
            state_d = SEARCH;
            err_d   = 8'd0;
          end
        end
        SEARCH: begin
          if (!train_i) begin
            state_d = IDLE;
            match_d = 8'd0;
          end else if (any_hit) begin
            shift_d = first_hit;
            match_d = 8'd1;
            state_d = (LOCK_CNT_C == 8'd1) ? LOCKED : VERIFY;
          end
        end
        VERIFY: begin
          if (!train_i) begin
            state_d = IDLE;
            match_d = 8'd0;
          end else if (!cur_ok) begin
            state_d = SEARCH;
            match_d = 8'd0;
            err_d   = 8'd0;
          end else begin
            match_d = match_q + 8'd1;
            if (match_q + 8'd1 == LOCK_CNT_C) state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (train_i && !cur_ok && (err_q != 8'hff)) err_d = err_q + 8'd1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Status rises one cycle after LOCKED is entered but drops on the same edge it is left.
  assign locked_d = (state_q == LOCKED) && (state_d == LOCKED);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      prev_q   <= 48'd0;
      out_q    <= 48'd0;
      shift_q  <= 4'd0;
      match_q  <= 8'd0;
      err_q    <= 8'd0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= in_i;
      out_q    <= out_d;
      shift_q  <= shift_d;
      match_q  <= match_d;
      err_q    <= err_d;
      locked_q <= locked_d;
    end
  end

  assign out_o     = out_q;
  assign valid_o   = locked_q;
  assign locked_o  = locked_q;
  assign shift_o   = shift_q;
  assign err_cnt_o = err_q;

endmodule
`default_nettype wire
